// File: rtl/dmem_lsu.sv
// Data memory with load/store unit: byte/half/word access with sign or zero
// extension, a fixed access latency and valid/ready handshakes on both sides.
module dmem_lsu #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic             accept;
  logic             commit;
  logic             op_we;
  logic [1:0]       op_size;
  logic             op_uns;
  logic [31:0]      op_addr;
  logic [31:0]      op_wdata;
  logic             op_err;
  logic [IDX_W-1:0] op_idx;
  logic [3:0]       lane_mask;
  logic [31:0]      lane_data;
  logic [31:0]      rd_word;

  // Pick the addressed byte or half out of a word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off,
                                              input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   load_extend = {{24{b[7] & ~uns}}, b};
      2'b01:   load_extend = {{16{h[15] & ~uns}}, h};
      default: load_extend = word;
    endcase
  endfunction

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign accept    = req_valid && (state_q == IDLE);
  // With LATENCY=1 the accept edge is also the commit edge, so the live request is used.
  assign commit    = ((state_q == IDLE) && accept && (LATENCY == 1)) ||
                     ((state_q == BUSY) && (cnt_q == 4'd1));

  // Operation fields, error decode, lane selection and array read for the commit edge.
  always_comb begin
    if (state_q == IDLE) begin
      op_we    = req_we;
      op_size  = req_size;
      op_uns   = req_unsigned;
      op_addr  = req_addr;
      op_wdata = req_wdata;
    end else begin
      op_we    = we_q;
      op_size  = size_q;
      op_uns   = uns_q;
      op_addr  = addr_q;
      op_wdata = wdata_q;
    end
    op_err = 1'b0;
    case (op_size)
      2'b01:   op_err = op_addr[0];
      2'b10:   op_err = |op_addr[1:0];
      2'b11:   op_err = 1'b1;
      default: op_err = 1'b0;
    endcase
    if ({2'b00, op_addr[31:2]} >= 32'(DEPTH)) op_err = 1'b1;
    op_idx = op_addr[IDX_W+1:2];
    case (op_size)
      2'b00: begin
        lane_mask = 4'b0001 << op_addr[1:0];
        lane_data = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        lane_mask = op_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{op_wdata[15:0]}};
      end
      default: begin
        lane_mask = 4'b1111;
        lane_data = op_wdata;
      end
    endcase
    rd_word = mem[op_idx];
  end

  // Next-state logic: IDLE -> (BUSY) -> RESP -> IDLE with the latency countdown.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture on accept and response formation on the commit edge.
  always_comb begin
    we_d    = accept ? req_we       : we_q;
    size_d  = accept ? req_size     : size_q;
    uns_d   = accept ? req_unsigned : uns_q;
    addr_d  = accept ? req_addr     : addr_q;
    wdata_d = accept ? req_wdata    : wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (commit) begin
      err_d   = op_err;
      rdata_d = (op_err || op_we) ? 32'd0
                                  : load_extend(rd_word, op_size, op_addr[1:0], op_uns);
    end
  end

  // Control and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Captured request fields; only meaningful once accepted, so no reset.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    size_q  <= size_d;
    uns_q   <= uns_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // Byte-lane store on the commit edge; reset on that edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset && commit && op_we && !op_err) begin
      if (lane_mask[0]) mem[op_idx][7:0]   <= lane_data[7:0];
      if (lane_mask[1]) mem[op_idx][15:8]  <= lane_data[15:8];
      if (lane_mask[2]) mem[op_idx][23:16] <= lane_data[23:16];
      if (lane_mask[3]) mem[op_idx][31:24] <= lane_data[31:24];
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: three instances (LATENCY 2, 1, 4), directed vector table,
// hand-written handshake/reset sequences and random traffic against a byte model.
module tb_dmem_lsu;

  logic        clk;
  logic [2:0]  reset;
  logic [2:0]  req_valid;
  logic [2:0]  req_we;
  logic [2:0]  req_unsigned;
  logic [2:0]  rsp_ready;
  logic [1:0]  req_size  [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  wire  [2:0]  req_ready;
  wire  [2:0]  rsp_valid;
  wire  [2:0]  rsp_err;
  wire  [31:0] rsp_rdata [3];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_lsu #(
      .DEPTH  (256),
      .LATENCY((g == 0) ? 2 : ((g == 1) ? 1 : 4))
    ) u_dut (
      .clk         (clk),
      .reset       (reset[g]),
      .req_valid   (req_valid[g]),
      .req_ready   (req_ready[g]),
      .req_we      (req_we[g]),
      .req_size    (req_size[g]),
      .req_unsigned(req_unsigned[g]),
      .req_addr    (req_addr[g]),
      .req_wdata   (req_wdata[g]),
      .rsp_valid   (rsp_valid[g]),
      .rsp_ready   (rsp_ready[g]),
      .rsp_rdata   (rsp_rdata[g]),
      .rsp_err     (rsp_err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Byte-addressed reference memory.
  logic [7:0] mb [1024];
  bit         kn [1024];

  function automatic void model_exp(input logic we, input logic [1:0] sz, input logic uns,
                                    input logic [31:0] a, output logic [31:0] rd,
                                    output logic er);
    int     nb;
    longint v;
    nb = (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
    er = (sz == 2'd3) || ((a % nb) != 0) || (a >= 32'd1024);
    rd = 32'd0;
    if (!er && !we) begin
      v = 0;
      for (int i = 0; i < nb; i++) v = v + (longint'(mb[a + i]) << (8 * i));
      if (!uns && nb < 4 && v >= (64'sd1 << (8 * nb - 1))) v = v - (64'sd1 << (8 * nb));
      rd = v[31:0];
    end
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int nb;
    nb = (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
    for (int i = 0; i < nb; i++) begin
      mb[a + i] = wd[8*i +: 8];
      kn[a + i] = 1'b1;
    end
  endtask

  // Issue one request on instance d and wait for its response (rsp_ready held high).
  // Entered and left at #1 after a rising edge with the instance idle.
  task automatic do_op(input int d, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat);
    req_valid[d] = 1'b1; req_we[d] = we; req_size[d] = sz;
    req_unsigned[d] = uns; req_addr[d] = a; req_wdata[d] = wd;
    @(posedge clk); #1;
    req_valid[d] = 1'b0; req_we[d] = ~we; req_size[d] = ~sz;
    req_unsigned[d] = ~uns; req_addr[d] = a ^ 32'h4; req_wdata[d] = ~wd;
    lat = 1;
    while (!rsp_valid[d] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("rsp_seen", 32'(rsp_valid[d]), 32'd1);
    rd = rsp_rdata[d];
    er = rsp_err[d];
    @(posedge clk); #1;
    chk("exit_idle", {30'd0, rsp_valid[d], req_ready[d]}, 32'd1);
  endtask

  task automatic run0(input string nm, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] erd, input logic eer);
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_op(0, we, sz, uns, a, wd, rd, er, lat);
    chk({nm, "_err"}, 32'(er), 32'(eer));
    chk({nm, "_rdata"}, rd, erd);
    chk({nm, "_lat"}, lat, 32'd2);
    if (we && !eer) model_store(sz, a, wd);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] erd;
    logic        eer;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] erd, input logic eer);
    vec_t v;
    v.we = we; v.sz = sz; v.uns = uns; v.addr = a; v.wd = wd; v.erd = erd; v.eer = eer;
    tbl.push_back(v);
  endtask

  initial begin
    logic [31:0] rd, erd, a;
    logic        er, eer, we, uns;
    logic [1:0]  sz;
    int          lat, n;
    bit          seen;

    for (int i = 0; i < 1024; i++) kn[i] = 1'b0;
    reset = 3'b111; req_valid = 3'b000; rsp_ready = 3'b111;
    req_we = 3'b000; req_unsigned = 3'b000;
    for (int d = 0; d < 3; d++) begin
      req_size[d] = 2'd0; req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
    end

    // Plain reset.
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_ready", 32'(req_ready[d]), 32'd1);
      chk("rst_valid", 32'(rsp_valid[d]), 32'd0);
      chk("rst_rdata", rsp_rdata[d], 32'd0);
      chk("rst_err", 32'(rsp_err[d]), 32'd0);
    end

    // Reset held while a request is offered: nothing may be accepted.
    for (int d = 0; d < 3; d++) begin
      req_valid[d] = 1'b1; req_we[d] = 1'b0; req_size[d] = 2'd2; req_addr[d] = 32'h64;
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 3'b000; req_valid = 3'b000;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen = seen | (|rsp_valid);
    end
    chk("rst_no_accept", 32'(seen), 32'd0);
    chk("rst_ready_after", 32'(req_ready), 32'd7);

    // Store/load round trip with exact latency on every instance.
    for (int d = 0; d < 3; d++) begin
      do_op(d, 1'b1, 2'd2, 1'b0, 32'h64, 32'h19, rd, er, lat);
      chk("lat_sw", lat, lat_of(d));
      chk("lat_sw_err", 32'(er), 32'd0);
      chk("lat_sw_rdata", rd, 32'd0);
      do_op(d, 1'b0, 2'd2, 1'b0, 32'h64, 32'd0, rd, er, lat);
      chk("lat_lw", lat, lat_of(d));
      chk("lat_lw_rdata", rd, 32'h19);
      chk("lat_lw_err", 32'(er), 32'd0);
    end

    // Directed vectors on the LATENCY=2 instance.
    add(1, 2, 0, 32'h000, 32'h0BADC0DE, 32'h0,        0);
    add(1, 2, 0, 32'h080, 32'h11223344, 32'h0,        0);
    add(1, 0, 0, 32'h081, 32'h000000AB, 32'h0,        0);
    add(0, 2, 0, 32'h080, 32'h0,        32'h1122AB44, 0);
    add(0, 0, 0, 32'h081, 32'h0,        32'hFFFFFFAB, 0);
    add(0, 0, 1, 32'h081, 32'h0,        32'h000000AB, 0);
    add(0, 1, 0, 32'h082, 32'h0,        32'h00001122, 0);
    add(1, 1, 0, 32'h082, 32'h00008001, 32'h0,        0);
    add(0, 1, 0, 32'h082, 32'h0,        32'hFFFF8001, 0);
    add(0, 1, 1, 32'h082, 32'h0,        32'h00008001, 0);
    add(1, 0, 0, 32'h083, 32'hFFFFFF7E, 32'h0,        0);
    add(0, 2, 0, 32'h080, 32'h0,        32'h7E01AB44, 0);
    add(0, 0, 0, 32'h083, 32'h0,        32'h0000007E, 0);
    add(0, 1, 0, 32'h080, 32'h0,        32'hFFFFAB44, 0);
    add(0, 2, 0, 32'h066, 32'h0,        32'h0,        1);
    add(1, 2, 0, 32'h060, 32'hCAFEF00D, 32'h0,        0);
    add(1, 1, 0, 32'h063, 32'h00005555, 32'h0,        1);
    add(0, 2, 0, 32'h060, 32'h0,        32'hCAFEF00D, 0);
    add(1, 2, 0, 32'h400, 32'h12345678, 32'h0,        1);
    add(0, 2, 0, 32'h000, 32'h0,        32'h0BADC0DE, 0);
    add(0, 2, 0, 32'h080, 32'h0,        32'h7E01AB44, 0);
    add(0, 3, 0, 32'h080, 32'h0,        32'h0,        1);
    add(1, 3, 0, 32'h080, 32'hFFFFFFFF, 32'h0,        1);
    add(0, 2, 0, 32'h080, 32'h0,        32'h7E01AB44, 0);
    add(0, 1, 0, 32'h081, 32'h0,        32'h0,        1);
    add(0, 0, 0, 32'h400, 32'h0,        32'h0,        1);
    add(1, 2, 0, 32'h3FC, 32'hA55A5AA5, 32'h0,        0);
    add(0, 0, 0, 32'h3FF, 32'h0,        32'hFFFFFFA5, 0);
    foreach (tbl[i]) begin
      run0($sformatf("vec%0d", i), tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].addr,
           tbl[i].wd, tbl[i].erd, tbl[i].eer);
    end

    // Backpressure: response held for three cycles, then a back-to-back request.
    rsp_ready[0] = 1'b0;
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_size[0] = 2'd2;
    req_unsigned[0] = 1'b0; req_addr[0] = 32'h80; req_wdata[0] = 32'd0;
    @(posedge clk); #1;
    req_valid[0] = 1'b0; req_addr[0] = 32'h60;
    n = 1;
    while (!rsp_valid[0] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_lat", n, 32'd2);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(rsp_valid[0]), 32'd1);
      chk("bp_rdata", rsp_rdata[0], 32'h7E01AB44);
      chk("bp_err", 32'(rsp_err[0]), 32'd0);
      chk("bp_ready", 32'(req_ready[0]), 32'd0);
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(rsp_valid[0]), 32'd0);
    chk("bp_release_ready", 32'(req_ready[0]), 32'd1);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_size[0] = 2'd0;
    req_unsigned[0] = 1'b1; req_addr[0] = 32'h81;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    chk("bp_next_accept", 32'(req_ready[0]), 32'd0);
    n = 1;
    while (!rsp_valid[0] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_next_lat", n, 32'd2);
    chk("bp_next_rdata", rsp_rdata[0], 32'h000000AB);
    @(posedge clk); #1;

    // Reset in BUSY drops a pending store.
    run0("mr_old", 1'b1, 2'd2, 1'b0, 32'h70, 32'h01020304, 32'h0, 1'b0);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_size[0] = 2'd2;
    req_unsigned[0] = 1'b0; req_addr[0] = 32'h70; req_wdata[0] = 32'hDEADBEEF;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    chk("mr_busy", {30'd0, rsp_valid[0], req_ready[0]}, 32'd0);
    reset[0] = 1'b1;
    @(posedge clk); #1;
    chk("mr_rst_valid", 32'(rsp_valid[0]), 32'd0);
    reset[0] = 1'b0;
    chk("mr_ready", 32'(req_ready[0]), 32'd1);
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      seen = seen | rsp_valid[0];
    end
    chk("mr_no_rsp", 32'(seen), 32'd0);
    run0("mr_load", 1'b0, 2'd2, 1'b0, 32'h70, 32'h0, 32'h01020304, 1'b0);

    // Random traffic against the byte model over a preloaded window.
    for (int i = 0; i < 16; i++) begin
      run0("init", 1'b1, 2'd2, 1'b0, 32'h100 + 32'(4 * i), $urandom, 32'h0, 1'b0);
    end
    for (int i = 0; i < 200; i++) begin
      we  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      n   = $urandom_range(0, 9);
      sz  = (n < 3) ? 2'd0 : ((n < 6) ? 2'd1 : ((n < 9) ? 2'd2 : 2'd3));
      n   = $urandom_range(0, 9);
      if (n == 0)      a = 32'h400 + 32'($urandom_range(0, 255));
      else if (n == 1) a = (32'h100 + 32'($urandom_range(0, 63))) | (32'h1 << $urandom_range(10, 31));
      else             a = 32'h100 + 32'($urandom_range(0, 63));
      model_exp(we, sz, uns, a, erd, eer);
      run0($sformatf("rnd%0d", i), we, sz, uns, a, $urandom, erd, eer);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
